// File: rtl/laplace_ventana.sv
// Streaming 5-point cross-window generator for the Laplace filter core (two line buffers, valid/ready).
// Define LAPLACE_VENTANA_EOL_EN to add the registered out_eol/out_eof markers.
module laplace_ventana #(
    parameter int COLS = 512,
    parameter int ROWS = 512,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_pixel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] b,
    output logic [DW-1:0] d,
    output logic [DW-1:0] e,
    output logic [DW-1:0] f,
    output logic [DW-1:0] h,
    output logic          frame_done
`ifdef LAPLACE_VENTANA_EOL_EN
    ,
    output logic          out_eol,
    output logic          out_eof
`endif
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    typedef enum logic [1:0] {FILL, STREAM, DRAIN} state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [DW-1:0] lb1 [COLS];
    logic [DW-1:0] lb2 [COLS];

    logic [DW-1:0] rd1, rd2;
    logic [DW-1:0] up1_d1, up1_d2, up2_d1, pix_d1;
    logic          accept, col_last, row_last, trigger;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    assign trigger  = (row >= RW'(2)) && (col >= CW'(2));
    assign rd1      = lb1[col];
    assign rd2      = lb2[col];

    // Line buffers carry no reset; FILL rewrites both rows before any read reaches the outputs.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[col] <= rd1;
            lb1[col] <= in_pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            col        <= '0;
            row        <= '0;
            up1_d1     <= '0;
            up1_d2     <= '0;
            up2_d1     <= '0;
            pix_d1     <= '0;
            out_valid  <= 1'b0;
            b          <= '0;
            d          <= '0;
            e          <= '0;
            f          <= '0;
            h          <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (accept) begin
                up1_d1 <= rd1;
                up1_d2 <= up1_d1;
                up2_d1 <= rd2;
                pix_d1 <= in_pixel;

                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end

                out_valid <= trigger;
                if (trigger) begin
                    b <= up2_d1;
                    d <= up1_d2;
                    e <= up1_d1;
                    f <= rd1;
                    h <= pix_d1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                FILL: begin
                    if (accept && row == RW'(1) && col_last)
                        state <= STREAM;
                end
                STREAM: begin
                    if (accept && row_last && col_last)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // A pixel accepted here is (0,0) of the next frame; counters already wrapped.
                    if (out_valid && out_ready) begin
                        frame_done <= 1'b1;
                        state      <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

`ifdef LAPLACE_VENTANA_EOL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_eol <= 1'b0;
            out_eof <= 1'b0;
        end else if (accept) begin
            out_eol <= trigger && col_last;
            out_eof <= trigger && col_last && row_last;
        end else if (out_ready) begin
            out_eol <= 1'b0;
            out_eof <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_laplace_ventana.sv
// Scoreboard bench for laplace_ventana on 5x5 frames: expected windows are built from the pixels sent.
module tb_laplace_ventana;

    localparam int COLS = 5;
    localparam int ROWS = 5;
    localparam int DW   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_pixel;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] b, d, e, f, h;
    logic          frame_done;
`ifdef LAPLACE_VENTANA_EOL_EN
    logic          out_eol, out_eof;
`endif

    laplace_ventana #(.COLS(COLS), .ROWS(ROWS), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready),
        .b(b), .d(d), .e(e), .f(f), .h(h),
        .frame_done(frame_done)
`ifdef LAPLACE_VENTANA_EOL_EN
        , .out_eol(out_eol), .out_eof(out_eof)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5*DW-1:0] win;
        logic            last;
        logic            eol;
    } exp_t;

    exp_t            q[$];
    logic [5*DW-1:0] got[$];
    logic [DW-1:0]   img [ROWS][COLS];

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_fd     = 0;
    int   m_r      = 0;
    int   m_c      = 0;
    int   cyc      = 0;
    bit   bp       = 1'b0;
    logic tb_ov    = 1'b0;
    logic fd_exp   = 1'b0;
    logic stall    = 1'b0;
    logic [5*DW-1:0] stall_win;
    logic [5*DW-1:0] win_now;

    assign win_now = {b, d, e, f, h};

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge, between active edges.
    always @(negedge clk) begin
        exp_t x;
        logic trig;
        if (rst) begin
            check_val("rst_out_valid", out_valid, 1'b0);
            check_val("rst_in_ready", in_ready, 1'b1);
            check_val("rst_frame_done", frame_done, 1'b0);
            check_val("rst_window", win_now, '0);
            tb_ov  = 1'b0;
            fd_exp = 1'b0;
            stall  = 1'b0;
            m_r    = 0;
            m_c    = 0;
            q.delete();
        end else begin
            check_val("out_valid", out_valid, tb_ov);
            check_val("in_ready", in_ready, !tb_ov || out_ready);
            check_val("frame_done", frame_done, fd_exp);
            if (frame_done) n_fd++;
            if (stall) check_val("stall_hold", win_now, stall_win);

            fd_exp = 1'b0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check_val("extra_window", 1'b1, 1'b0);
                end else begin
                    x = q.pop_front();
                    check_val("window", win_now, x.win);
`ifdef LAPLACE_VENTANA_EOL_EN
                    check_val("out_eol", out_eol, x.eol);
                    check_val("out_eof", out_eof, x.last);
`endif
                    fd_exp = x.last;
                end
                got.push_back(win_now);
            end
            stall     = out_valid && !out_ready;
            stall_win = win_now;

            trig = 1'b0;
            if (in_valid && in_ready) begin
                img[m_r][m_c] = in_pixel;
                if (m_r >= 2 && m_c >= 2) begin
                    trig   = 1'b1;
                    x.win  = {img[m_r-2][m_c-1], img[m_r-1][m_c-2], img[m_r-1][m_c-1],
                              img[m_r-1][m_c], img[m_r][m_c-1]};
                    x.last = (m_r == ROWS - 1) && (m_c == COLS - 1);
                    x.eol  = (m_c == COLS - 1);
                    q.push_back(x);
                end
                if (m_c == COLS - 1) begin
                    m_c = 0;
                    m_r = (m_r == ROWS - 1) ? 0 : m_r + 1;
                end else begin
                    m_c = m_c + 1;
                end
                tb_ov = trig;
            end else if (out_ready) begin
                tb_ov = 1'b0;
            end
        end
    end

    task automatic send_frame(input int base, input bit gaps, input int npix);
        int idx   = 0;
        int guard = 0;
        while (idx < npix && guard < 2000) begin
            @(posedge clk);
            #1;
            in_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_pixel  = DW'(base + 10 * (idx / COLS) + idx % COLS);
            out_ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            cyc++;
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            guard++;
        end
        if (guard >= 2000) check_val("send_timeout", 1'b1, 1'b0);
    endtask

    task automatic drain();
        int guard = 0;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_val("drain_timeout", guard < 200, 1'b1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        got.delete();
        n_fd = 0;
    endtask

    initial begin
        logic [5*DW-1:0] w;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pixel  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic frame
        clear_log();
        send_frame(0, 1'b0, ROWS * COLS);
        drain();
        check_val("basic_count", got.size(), 9);
        check_val("basic_frame_done", n_fd, 1);
        if (got.size() == 9) begin
            w = got[0];
            check_val("basic_first", w, {8'd1, 8'd10, 8'd11, 8'd12, 8'd21});
            w = got[8];
            check_val("basic_last", w, {8'd23, 8'd32, 8'd33, 8'd34, 8'd43});
        end

        // Backpressure 1,0,0,1
        clear_log();
        bp = 1'b1;
        send_frame(0, 1'b0, ROWS * COLS);
        drain();
        bp = 1'b0;
        check_val("bp_count", got.size(), 9);
        check_val("bp_frame_done", n_fd, 1);

        // Input gaps
        clear_log();
        send_frame(0, 1'b1, ROWS * COLS);
        drain();
        check_val("gap_count", got.size(), 9);
        check_val("gap_frame_done", n_fd, 1);

        // Back-to-back frames
        clear_log();
        send_frame(0, 1'b0, ROWS * COLS);
        send_frame(100, 1'b0, ROWS * COLS);
        drain();
        check_val("b2b_count", got.size(), 18);
        check_val("b2b_frame_done", n_fd, 2);
        if (got.size() == 18) begin
            w = got[9];
            check_val("b2b_f2_first", w, {8'd101, 8'd110, 8'd111, 8'd112, 8'd121});
        end

        // Reset after 13 pixels, then a full frame
        send_frame(0, 1'b0, 13);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
        send_frame(0, 1'b0, ROWS * COLS);
        drain();
        check_val("rst_count", got.size(), 9);
        check_val("rst_frame_done", n_fd, 1);
        if (got.size() == 9) begin
            w = got[0];
            check_val("rst_first", w, {8'd1, 8'd10, 8'd11, 8'd12, 8'd21});
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
